// File: rtl/lsu_pkg.sv
// Shared types and constants for the MEM-stage load/store unit.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package lsu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_REQ    = 2'd1,
    ST_WAIT_R = 2'd2,
    ST_DONE   = 2'd3
  } lsu_state_e;

  // Access size lives in funct3[1:0]; funct3[2] selects zero-extension.
  // Any size code with bit 1 set (010, 011, 110, 111) is a word access.
  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;

  localparam logic [3:0] EXC_LD_MIS = 4'd4;
  localparam logic [3:0] EXC_LD_FLT = 4'd5;
  localparam logic [3:0] EXC_ST_MIS = 4'd6;
  localparam logic [3:0] EXC_ST_FLT = 4'd7;
  localparam logic [3:0] EXC_NONE   = 4'hF;

  // Natural alignment check for a given funct3 and the two low address bits.
  function automatic logic is_aligned(input logic [2:0] f3, input logic [1:0] a);
    logic ok;
    case (f3[1:0])
      SZ_B:    ok = 1'b1;
      SZ_H:    ok = ~a[0];
      default: ok = (a == 2'b00);
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Lane steering: byte enables, store-data replication, load shift and extension.
// Latency: combinational.
// Backpressure: none; pure function of its inputs.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [1:0]  i_addr_lo,
  input  logic [2:0]  i_f3,
  input  logic [31:0] i_wdata,
  input  logic [31:0] i_rdata,
  output logic [3:0]  o_be,
  output logic [31:0] o_wdata,
  output logic [31:0] o_rdata
);

  logic [31:0] rd_shift;

  // Select lanes for stores and right-justify/extend load data by access size.
  always_comb begin
    rd_shift = i_rdata >> {i_addr_lo, 3'b000};
    o_be     = 4'b1111;
    o_wdata  = i_wdata;
    o_rdata  = rd_shift;
    case (i_f3[1:0])
      SZ_B: begin
        o_be    = 4'b0001 << i_addr_lo;
        o_wdata = {4{i_wdata[7:0]}};
        o_rdata = i_f3[2] ? {24'b0, rd_shift[7:0]}
                          : {{24{rd_shift[7]}}, rd_shift[7:0]};
      end
      SZ_H: begin
        o_be    = 4'b0011 << {i_addr_lo[1], 1'b0};
        o_wdata = {2{i_wdata[15:0]}};
        o_rdata = i_f3[2] ? {16'b0, rd_shift[15:0]}
                          : {{16{rd_shift[15]}}, rd_shift[15:0]};
      end
      default: begin
        o_be    = 4'b1111;
        o_wdata = i_wdata;
        o_rdata = rd_shift;
      end
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// MEM-stage load/store engine: one bus transaction per access, stalls the pipe meanwhile.
// Latency: store 2 + ready-wait cycles; load 3 + ready-wait + rvalid-wait cycles.
// Backpressure: request held until i_bus_ready; optional watchdog under LSU_TIMEOUT_EN.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_clk_en,
  input  logic              i_req_m,
  input  logic              i_we_m,
  input  logic [2:0]        i_f3_m,
  input  logic [ADDR_W-1:0] i_addr_m,
  input  logic [31:0]       i_wdata_m,
  output logic [31:0]       o_rdata_m,
  output logic              o_done,
  output logic              o_stall,
  output logic [3:0]        o_exc_code,
  output logic              o_bus_req,
  output logic              o_bus_we,
  output logic [ADDR_W-1:0] o_bus_addr,
  output logic [31:0]       o_bus_wdata,
  output logic [3:0]        o_bus_be,
  input  logic              i_bus_ready,
  input  logic              i_bus_rvalid,
  input  logic [31:0]       i_bus_rdata,
  input  logic              i_bus_err
);

  lsu_state_e        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [2:0]        f3_q, f3_d;
  logic              we_q, we_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       rdata_q, rdata_d;
  logic [3:0]        exc_q, exc_d;

  logic        aligned, req_ok, bus_req, timeout;
  logic [3:0]  lane_be;
  logic [31:0] lane_wdata, load_fmt;

  lsu_align u_align (
    .i_addr_lo (addr_q[1:0]),
    .i_f3      (f3_q),
    .i_wdata   (wdata_q),
    .i_rdata   (i_bus_rdata),
    .o_be      (lane_be),
    .o_wdata   (lane_wdata),
    .o_rdata   (load_fmt)
  );

  assign aligned = is_aligned(i_f3_m, i_addr_m[1:0]);
  // Reset also silences the combinational IDLE responses so nothing leaks while held.
  assign req_ok  = i_req_m & i_rst_n;
  assign bus_req = (state_q == ST_REQ);

  assign o_bus_req   = bus_req;
  assign o_bus_we    = bus_req & we_q;
  assign o_bus_addr  = bus_req ? {addr_q[ADDR_W-1:2], 2'b00} : '0;
  assign o_bus_wdata = bus_req ? lane_wdata : 32'b0;
  assign o_bus_be    = bus_req ? lane_be : 4'b0;

`ifdef LSU_TIMEOUT_EN
  logic [7:0] cnt_q, cnt_d;

  // Bus-wait counter: cleared on REQ entry, saturating count while waiting on the bus.
  always_comb begin
    cnt_d = cnt_q;
    if (state_q == ST_IDLE) begin
      cnt_d = 8'd0;
    end else if ((state_q == ST_REQ || state_q == ST_WAIT_R) && cnt_q != 8'hFF) begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  // Counter register; frozen while the clock enable is low.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt_q <= 8'd0;
    end else if (i_clk_en) begin
      cnt_q <= cnt_d;
    end
  end

  // Expires on the TIMEOUT_CYC-th waiting cycle.
  assign timeout = (cnt_q >= 8'(TIMEOUT_CYC - 1));
`else
  // Watchdog compiled out; the term only keeps the parameter referenced.
  assign timeout = 1'b0 & (TIMEOUT_CYC != 0);
`endif

  // Next-state, request capture and pipeline-facing outputs.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    f3_d       = f3_q;
    we_d       = we_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    exc_d      = exc_q;
    o_stall    = 1'b0;
    o_done     = 1'b0;
    o_exc_code = EXC_NONE;
    o_rdata_m  = 32'b0;
    case (state_q)
      ST_IDLE: begin
        if (req_ok && aligned) begin
          o_stall = 1'b1;
          if (i_clk_en) begin
            addr_d  = i_addr_m;
            f3_d    = i_f3_m;
            we_d    = i_we_m;
            wdata_d = i_wdata_m;
            state_d = ST_REQ;
          end
        end else if (req_ok) begin
          // Misaligned: trap immediately without touching the bus.
          o_done     = 1'b1;
          o_exc_code = i_we_m ? EXC_ST_MIS : EXC_LD_MIS;
        end
      end
      ST_REQ: begin
        o_stall = 1'b1;
        if (i_clk_en) begin
          if (i_bus_ready) begin
            if (we_q) begin
              state_d = ST_DONE;
              exc_d   = i_bus_err ? EXC_ST_FLT : EXC_NONE;
              rdata_d = 32'b0;
            end else begin
              state_d = ST_WAIT_R;
            end
          end else if (timeout) begin
            state_d = ST_DONE;
            exc_d   = we_q ? EXC_ST_FLT : EXC_LD_FLT;
            rdata_d = 32'b0;
          end
        end
      end
      ST_WAIT_R: begin
        o_stall = 1'b1;
        if (i_clk_en) begin
          if (i_bus_rvalid) begin
            state_d = ST_DONE;
            exc_d   = i_bus_err ? EXC_LD_FLT : EXC_NONE;
            rdata_d = i_bus_err ? 32'b0 : load_fmt;
          end else if (timeout) begin
            state_d = ST_DONE;
            exc_d   = EXC_LD_FLT;
            rdata_d = 32'b0;
          end
        end
      end
      default: begin
        o_done     = 1'b1;
        o_exc_code = exc_q;
        o_rdata_m  = rdata_q;
        if (i_clk_en) begin
          state_d = ST_IDLE;
        end
      end
    endcase
  end

  // State and request registers; all hold while the clock enable is low.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      f3_q    <= 3'b0;
      we_q    <= 1'b0;
      wdata_q <= 32'b0;
      rdata_q <= 32'b0;
      exc_q   <= EXC_NONE;
    end else if (i_clk_en) begin
      state_q <= state_d;
      addr_q  <= addr_d;
      f3_q    <= f3_d;
      we_q    <= we_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      exc_q   <= exc_d;
    end
  end

endmodule
